// File: rtl/if_fetch_pkg.sv
// Shared types and encodings for the instruction-fetch stage.
// Used by if_fetch and if_inst_fifo.
package if_fetch_pkg;

    typedef enum logic [1:0] {
        IF_IDLE    = 2'b00,
        IF_REQ     = 2'b01,
        IF_DISCARD = 2'b10
    } if_state_e;

    localparam int unsigned InstAddrBus  = 32;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam logic        CHIP_ENABLE  = 1'b1;
    localparam logic        CHIP_DISABLE = 1'b0;

endpackage

// File: rtl/if_inst_fifo.sv
// Synchronous instruction buffer with push, pop and clear.
// The head output holds its last value while the buffer is empty.
module if_inst_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   clear_i,
    input  logic [Width-1:0]       wdata_i,
    output logic [Width-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [PtrW:0]    count_q;
    logic [Width-1:0] hold_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PtrW + 1)'(Depth));
    assign count_o = count_q;
    assign do_pop  = pop_i & ~clear_i & ~empty_o;
    assign do_push = push_i & ~clear_i & (~full_o | do_pop);
    assign rdata_o = empty_o ? hold_q : mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            hold_q  <= '0;
        end else begin
            // Track the head so it can be replayed once the buffer drains.
            if (!empty_o) begin
                hold_q <= mem_q[rptr_q];
            end
            if (clear_i) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
            end else begin
                if (do_push) begin
                    wptr_q <= wptr_q + PtrW'(1);
                end
                if (do_pop) begin
                    rptr_q <= rptr_q + PtrW'(1);
                end
                if (do_push && !do_pop) begin
                    count_q <= count_q + (PtrW + 1)'(1);
                end else if (do_pop && !do_push) begin
                    count_q <= count_q - (PtrW + 1)'(1);
                end
            end
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: issues req/ack word reads, buffers results, flushes on redirect.
// Optional FETCH_MISALIGN_CHECK_EN turns misaligned PCs into flagged NOPs without a memory read.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned ADDR_W     = InstAddrBus,
    parameter int unsigned INST_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    output logic              pc_stall_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [INST_W-1:0] mem_rdata_i,
    input  logic              stall_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic              inst_misalign_o,
`endif
    output logic [ADDR_W-1:0] inst_pc_o
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam int unsigned EntW = ADDR_W + INST_W + 1;
`else
    localparam int unsigned EntW = ADDR_W + INST_W;
`endif

    if_state_e         state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              outstanding, space, accept, misalign;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CntW-1:0]   fifo_count;
    logic [ADDR_W-1:0] push_pc;
    logic [INST_W-1:0] push_inst;
    logic [EntW-1:0]   push_data, head_data;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign  = |pc_i[1:0];
    // Pushes from IDLE can only be synthesized NOPs for misaligned PCs.
    assign push_data = {push_pc, push_inst, state_q == IF_IDLE};
    assign inst_misalign_o = head_data[0];
`else
    assign misalign  = 1'b0;
    assign push_data = {push_pc, push_inst};
`endif

    assign outstanding = (state_q != IF_IDLE);
    assign space = ~fifo_full & ((int'(fifo_count) + int'(outstanding)) < int'(FIFO_DEPTH));
    // Misaligned PCs are only taken from IDLE so a cycle never needs two pushes.
    assign accept = (ce_i == CHIP_ENABLE) & ~flush_i & space &
                    ((state_q == IF_IDLE) | ((state_q == IF_REQ) & mem_ack_i & ~misalign));

    assign pc_stall_o   = ce_i & ~accept;
    assign mem_req_o    = req_q;
    assign mem_addr_o   = addr_q;
    assign inst_valid_o = ~fifo_empty;
    assign fifo_pop     = ~fifo_empty & ~stall_i & ~flush_i;
    assign inst_pc_o    = head_data[EntW-1 -: ADDR_W];
    assign inst_o       = head_data[EntW-ADDR_W-1 -: INST_W];

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        fifo_push = 1'b0;
        push_pc   = addr_q;
        push_inst = mem_rdata_i;
        unique case (state_q)
            IF_IDLE: begin
                if (accept && misalign) begin
                    fifo_push = 1'b1;
                    push_pc   = pc_i;
                    push_inst = INST_W'(NOP_INST);
                end else if (accept) begin
                    req_d   = 1'b1;
                    addr_d  = pc_i;
                    state_d = IF_REQ;
                end
            end
            IF_REQ: begin
                if (flush_i) begin
                    if (mem_ack_i) begin
                        req_d   = 1'b0;
                        state_d = IF_IDLE;
                    end else begin
                        state_d = IF_DISCARD;
                    end
                end else if (mem_ack_i) begin
                    fifo_push = 1'b1;
                    if (accept) begin
                        addr_d = pc_i;
                    end else begin
                        req_d   = 1'b0;
                        state_d = IF_IDLE;
                    end
                end
            end
            IF_DISCARD: begin
                if (mem_ack_i) begin
                    req_d   = 1'b0;
                    state_d = IF_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IF_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IF_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    if_inst_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (EntW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .clear_i (flush_i),
        .wdata_i (push_data),
        .rdata_o (head_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios followed by randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_if_fetch;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_i = '0;
    logic        ce_i = 1'b0;
    logic        pc_stall_o;
    logic        flush_i = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        stall_i = 1'b0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;

    always #5 clk = ~clk;

    if_fetch #(
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (32),
        .INST_W     (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .ce_i         (ce_i),
        .pc_stall_o   (pc_stall_o),
        .flush_i      (flush_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .stall_i      (stall_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o)
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    // Reference model: buffered instructions, one outstanding read, and whether it is doomed.
    ent_t        q[$];
    bit          busy, drop;
    logic [31:0] m_addr, last_pc, last_inst;
    int          lat;
    logic [31:0] pc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        busy      = 1'b0;
        drop      = 1'b0;
        m_addr    = '0;
        last_pc   = '0;
        last_inst = '0;
        lat       = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 64'(inst_valid_o), 64'd0);
        chk({tag, "_inst"}, 64'(inst_o), 64'd0);
        chk({tag, "_pc"}, 64'(inst_pc_o), 64'd0);
        chk({tag, "_req"}, 64'(mem_req_o), 64'd0);
        chk({tag, "_addr"}, 64'(mem_addr_o), 64'd0);
        chk({tag, "_stall"}, 64'(pc_stall_o), 64'd0);
    endtask

    task automatic cycle(input bit ce, input bit fl, input bit st, input bit ak,
                         input logic [31:0] rd);
        bit acc, valid;
        @(negedge clk);
        ce_i        = ce;
        flush_i     = fl;
        stall_i     = st;
        mem_ack_i   = ak;
        pc_i        = pc;
        mem_rdata_i = rd;
        #1;
        valid = (q.size() != 0);
        acc = ce && !fl && ((q.size() + int'(busy)) < DEPTH) && (!busy || (!drop && ak));
        chk("valid", 64'(inst_valid_o), 64'(valid));
        chk("inst", 64'(inst_o), 64'(valid ? q[0].inst : last_inst));
        chk("inst_pc", 64'(inst_pc_o), 64'(valid ? q[0].pc : last_pc));
        chk("mem_req", 64'(mem_req_o), 64'(busy));
        chk("mem_addr", 64'(mem_addr_o), 64'(m_addr));
        chk("pc_stall", 64'(pc_stall_o), 64'(ce && !acc));
        if (valid) begin
            last_pc   = q[0].pc;
            last_inst = q[0].inst;
        end
        if (fl) begin
            q.delete();
            if (busy && ak) begin
                busy = 1'b0;
                drop = 1'b0;
            end else if (busy) begin
                drop = 1'b1;
            end
        end else begin
            if (valid && !st) void'(q.pop_front());
            if (busy && ak) begin
                if (!drop) q.push_back('{pc: m_addr, inst: rd});
                busy = 1'b0;
                drop = 1'b0;
            end
            if (acc) begin
                busy   = 1'b1;
                m_addr = pc;
                pc     = pc + 32'd4;
                lat    = $urandom_range(0, 3);
            end
        end
    endtask

    initial begin
        bit r_ce, r_fl, r_st, r_ak;
        model_reset();
        pc = '0;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Single fetch with one-cycle ack.
        cycle(1, 0, 0, 0, 32'h0);
        cycle(0, 0, 0, 1, 32'h0050_0093);
        cycle(0, 0, 0, 0, 32'h0);
        chk("tp1_inst", 64'(inst_o), 64'h0050_0093);
        chk("tp1_pc", 64'(inst_pc_o), 64'h0);

        // Back-to-back acks.
        pc = 32'h0;
        cycle(1, 0, 0, 0, $urandom);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1, $urandom);
        cycle(0, 0, 0, 1, $urandom);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, $urandom);

        // Downstream stall with 3-cycle ack latency fills the buffer.
        pc = 32'h0;
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, $urandom);
        cycle(1, 0, 1, 1, $urandom);
        for (int i = 0; i < 2; i++) cycle(1, 0, 1, 0, $urandom);
        cycle(1, 0, 1, 1, $urandom);
        for (int i = 0; i < 2; i++) cycle(1, 0, 1, 0, $urandom);
        chk("tp3_full_stall", 64'(pc_stall_o), 64'd1);
        chk("tp3_full_req", 64'(mem_req_o), 64'd0);
        cycle(0, 0, 0, 0, $urandom);
        chk("tp3_drain0", 64'(inst_pc_o), 64'h0);
        cycle(0, 0, 0, 0, $urandom);
        chk("tp3_drain1", 64'(inst_pc_o), 64'h4);
        cycle(0, 0, 0, 0, $urandom);

        // Flush while a request is outstanding; its data must vanish.
        pc = 32'h40;
        cycle(1, 0, 0, 0, $urandom);
        cycle(0, 1, 0, 0, $urandom);
        cycle(0, 0, 0, 0, $urandom);
        chk("tp4_discard_req", 64'(mem_req_o), 64'd1);
        cycle(0, 0, 0, 1, 32'hDEAD_BEEF);
        cycle(0, 0, 0, 0, $urandom);
        chk("tp4_no_valid", 64'(inst_valid_o), 64'd0);
        pc = 32'h100;
        cycle(1, 0, 0, 0, $urandom);
        cycle(0, 0, 0, 1, $urandom);
        cycle(0, 0, 0, 0, $urandom);
        chk("tp4_pc100", 64'(inst_pc_o), 64'h100);

        // Flush coincident with ack, then with pop.
        pc = 32'h200;
        cycle(1, 0, 0, 0, $urandom);
        cycle(0, 1, 0, 1, $urandom);
        cycle(0, 0, 0, 0, $urandom);
        chk("tp5_ack_flush", 64'(inst_valid_o), 64'd0);
        cycle(1, 0, 0, 0, $urandom);
        cycle(0, 0, 0, 1, $urandom);
        cycle(0, 1, 0, 0, $urandom);
        cycle(0, 0, 0, 0, $urandom);
        chk("tp5_pop_flush", 64'(inst_valid_o), 64'd0);

        // Asynchronous reset mid-request.
        pc = 32'h300;
        cycle(1, 0, 0, 0, $urandom);
        @(negedge clk);
        ce_i = 1'b0;
        mem_ack_i = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        pc = 32'h0;
        cycle(1, 0, 0, 0, $urandom);
        cycle(0, 0, 0, 1, $urandom);
        cycle(0, 0, 0, 0, $urandom);
        chk("tp6_restart_pc", 64'(inst_pc_o), 64'h0);

        // Randomized traffic.
        lat = 0;
        for (int i = 0; i < 800; i++) begin
            r_ce = ($urandom_range(0, 9) < 8);
            r_fl = ($urandom_range(0, 99) < 6);
            r_st = ($urandom_range(0, 9) < 3);
            r_ak = busy && (lat == 0);
            if (busy && lat > 0) lat--;
            cycle(r_ce, r_fl, r_st, r_ak, $urandom);
            if (r_fl) pc = $urandom & 32'hFFFF_FFFC;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current fetch address and chip-enable, issues word reads to instruction memory over a req/ack handshake, and buffers returned instructions in a small FIFO.
- Presents instructions, with their PCs, to the IF/ID pipeline register.
- Back-pressures the PC register through pc_stall_o, and discards in-flight work on a branch/jump flush.

Parameters:
- FIFO_DEPTH, 2: instruction buffer entries (power of two, at least 2).
- ADDR_W, 32: instruction address width.
- INST_W, 32: instruction width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- pc_i  in  ADDR_W  fetch address from the PC register.
- ce_i  in  1  chip enable from the PC register; pc_i is valid when high.
- pc_stall_o  out  1  PC register must hold pc_i this cycle.
- flush_i  in  1  discard all buffered and in-flight fetches.
- mem_req_o  out  1  memory read request.
- mem_addr_o  out  ADDR_W  memory read address.
- mem_ack_i  in  1  memory has returned data this cycle.
- mem_rdata_i  in  INST_W  returned instruction word.
- stall_i  in  1  downstream (IF/ID) cannot accept.
- inst_valid_o  out  1  inst_o and inst_pc_o are valid.
- inst_o  out  INST_W  instruction at FIFO head.
- inst_pc_o  out  ADDR_W  PC of instruction at FIFO head.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, FIFO empty.
  - mem_req_o=0, mem_addr_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0, pc_stall_o=0.
- FSM states:
  - IDLE: no request outstanding.
  - REQ: request outstanding, waiting for ack.
  - DISCARD: flushed request outstanding; its data will be dropped.
- Space condition: space = (fifo_count + outstanding) < FIFO_DEPTH.
- Accepting a PC: accept = ce_i & ~flush_i & space & (IDLE | (REQ & mem_ack_i)).
  - On accept, latch pc_i into mem_addr_o, assert mem_req_o, and go to (or stay in) REQ.
  - This gives back-to-back requests when ack and accept coincide.
- PC back-pressure: pc_stall_o = ce_i & ~accept. It is combinational and is asserted in DISCARD.
- Request stability: mem_req_o and mem_addr_o stay stable from issue until the cycle of mem_ack_i inclusive. A request is never withdrawn.
- Ack in REQ without a new accept: push {mem_addr_o, mem_rdata_i} into the FIFO, drop mem_req_o, go to IDLE.
- Latency: request issued at edge N and ack in cycle N+k gives inst_valid_o high in cycle N+k+1. There is no bypass.
- Output side:
  - inst_valid_o = FIFO non-empty; inst_o and inst_pc_o show the head entry.
  - Pop when inst_valid_o & ~stall_i.
  - Push and pop in the same cycle are allowed and leave the count unchanged.
  - When the FIFO is empty, inst_o and inst_pc_o hold their last value.
- ce_i low: no new request. An outstanding request still completes normally.
- Flush (flush_i high), effective at the next edge:
  - FIFO count goes to 0 and inst_valid_o goes low.
  - In REQ with no ack this cycle: go to DISCARD, mem_req_o stays high.
  - In REQ with ack this cycle: data is dropped, go to IDLE.
  - In IDLE: stay in IDLE.
  - Flush has priority over push, pop and accept in the same cycle.
- DISCARD: on mem_ack_i, drop the data, deassert mem_req_o, go to IDLE; no accept in that cycle. flush_i while in DISCARD keeps the state in DISCARD.
- FIFO full with stall_i held: space is 0, so no request is issued and pc_stall_o stays high while ce_i is high.
- Pointers: wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits wide.

Optional Feature:
- Macro FETCH_MISALIGN_CHECK_EN adds one output, inst_misalign_o (1 bit).
- Defined:
  - If an accepted pc_i has pc_i[1:0] != 0, no memory request is issued.
  - An entry {pc_i, 32'h00000013 (NOP), misalign=1} is pushed into the FIFO directly at the next edge; the FSM stays in IDLE.
  - inst_misalign_o shows the head entry's flag.
- Not defined: the port is absent, pc_i[1:0] is ignored, and all addresses go to memory unchanged.

Decomposition:
- Shared package / Defines.vh:
  - FSM state encodings IF_IDLE, IF_REQ, IF_DISCARD.
  - NOP encoding 32'h00000013.
  - Existing InstAddrBus, ZeroWord and ChipEnable/ChipDisable macros.
- One sub-module: if_inst_fifo, a synchronous FIFO.
  - Parameterised depth and width; push, pop and clear.
  - Outputs full, empty and count, plus head data.

Test Plan:
- Reset, then ce_i=1 with pc_i=0x0 and single-cycle ack -> mem_addr_o=0x0. With mem_rdata_i=0x00500093, inst_valid_o=1 the cycle after ack, inst_o=0x00500093, inst_pc_o=0x0.
- Back-to-back with pc_i 0x0, 0x4, 0x8 and ack every cycle, stall_i=0 -> one instruction per cycle, PCs in order, pc_stall_o stays 0.
- stall_i=1 held with 3-cycle ack latency -> FIFO fills to 2, then pc_stall_o=1 and mem_req_o=0. Releasing stall_i drains 0x0 then 0x4 in order.
- flush_i mid-request (ack 2 cycles later) -> inst_valid_o=0 next cycle, state DISCARD, and the returned word is never output. The next accepted pc_i=0x100 yields inst_pc_o=0x100.
- flush_i coincident with ack, and flush_i coincident with pop -> FIFO empty, no spurious inst_valid_o.
- rst low mid-request -> all outputs 0 immediately (asynchronous). After rst returns high, fetch restarts from pc_i cleanly.
